// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, fixed LATENCY,
// misaligned accesses flagged and suppressed, pipeline held via stall.
module dmem_responder #(
   parameter int DEPTH_BYTES = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic           ready_q;
   logic           valid_q;
   logic [63:0]    rdata_q;
   logic           err_q;

   logic           wr_q;
   logic [AW-1:0]  off_q;
   logic [63:0]    wdata_q;

   logic [7:0]     mem [DEPTH_BYTES];

   logic           idle;
   logic           accept;
   logic           commit;
   logic           c_write;
   logic [AW-1:0]  c_off;
   logic [63:0]    c_wdata;
   logic           c_mis;
   logic [63:0]    rd_word;

   assign idle    = (state_q == IDLE);
   assign accept  = reset & idle & req_valid;
   // With LATENCY == 1 the commit happens on the accept edge, so the live inputs are used.
   assign commit  = reset & ((accept && (LATENCY == 1)) ||
                             ((state_q == WAIT) && (cnt_q == CW'(1))));
   assign c_write = idle ? req_write : wr_q;
   assign c_off   = idle ? req_addr[AW-1:0] : off_q;
   assign c_wdata = idle ? req_wdata : wdata_q;
   assign c_mis   = (c_off[2:0] != 3'b000);

   always_comb begin
      rd_word = '0;
      for (int b = 0; b < 8; b++) begin
         rd_word[8*b +: 8] = mem[c_off | AW'(b)];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cnt_q   <= CW'(LATENCY - 1);
                  ready_q <= 1'b0;
                  state_q <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
         if (commit) begin
            valid_q <= 1'b1;
            err_q   <= c_mis;
            if (!c_write) rdata_q <= c_mis ? 64'd0 : rd_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_write;
         off_q   <= req_addr[AW-1:0];
         wdata_q <= req_wdata;
      end
   end

   // Storage has no reset; a store aborted by reset never reaches commit.
   always_ff @(posedge clk) begin
      if (commit && c_write && !c_mis) begin
         for (int b = 0; b < 8; b++) begin
            mem[c_off | AW'(b)] <= c_wdata[8*b +: 8];
         end
      end
   end

   assign req_ready  = ready_q;
   assign stall      = reset & ((idle & req_valid) | (state_q == WAIT));
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_dmem_responder;

   typedef struct {
      logic        err;
      logic [63:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n      [2];
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [63:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic        req_ready  [2];
   logic        stall      [2];
   logic        resp_valid [2];
   logic [63:0] resp_rdata [2];
   logic        resp_err   [2];

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_BYTES(64), .LATENCY(2)) u_dut0 (
      .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .stall(stall[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .resp_err(resp_err[0]));

   dmem_responder #(.DEPTH_BYTES(64), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .stall(stall[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .resp_err(resp_err[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon_check(input int d, input int qsize, input exp_t e);
      if (qsize == 0) begin
         chk($sformatf("unexpected_resp%0d", d), 64'd1, 64'd0);
      end else begin
         chk($sformatf("resp_err%0d", d), {63'd0, resp_err[d]}, {63'd0, e.err});
         chk($sformatf("resp_rdata%0d", d), resp_rdata[d], e.rd);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   n;
      if (resp_valid[0] === 1'b1) begin
         n = q0.size();
         e = '{1'b0, 64'd0};
         if (n != 0) e = q0.pop_front();
         mon_check(0, n, e);
      end
      if (resp_valid[1] === 1'b1) begin
         n = q1.size();
         e = '{1'b0, 64'd0};
         if (n != 0) e = q1.pop_front();
         mon_check(1, n, e);
      end
   end

   // Full access on instance 0 (LATENCY=2); called one cycle after a posedge, DUT idle.
   task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err);
      int stall_cnt;
      int edges;
      req_valid[0] = 1'b1;
      req_write[0] = wr;
      req_addr[0]  = addr;
      req_wdata[0] = wd;
      q0.push_back('{exp_err, exp_rd});
      #1;
      chk("ready_idle", {63'd0, req_ready[0]}, 64'd1);
      chk("stall_req", {63'd0, stall[0]}, 64'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_write[0] = 1'b1;
      req_addr[0]  = 64'hFFF8;
      req_wdata[0] = 64'hBADBADBADBADBAD0;
      stall_cnt = 1;
      edges = 0;
      while (resp_valid[0] !== 1'b1 && edges < 20) begin
         if (stall[0] === 1'b1) stall_cnt++;
         @(posedge clk); #1;
         edges++;
      end
      chk("resp_latency", 64'(edges), 64'd1);
      chk("stall_cycles", 64'(stall_cnt), 64'd2);
      @(posedge clk); #1;
      chk("ready_back", {63'd0, req_ready[0]}, 64'd1);
      chk("valid_drop", {63'd0, resp_valid[0]}, 64'd0);
   endtask

   logic        b_wr [8];
   logic [63:0] b_ad [8];
   logic [63:0] b_wd [8];
   logic [63:0] b_rd [8];
   logic        b_er [8];

   initial begin
      b_wr = '{1, 1, 0, 1, 0, 0, 1, 0};
      b_ad = '{64'h00, 64'h08, 64'h00, 64'h00, 64'h08, 64'h00, 64'h0C, 64'h08};
      b_wd = '{64'h0101010101010101, 64'h0202020202020202, 64'h0, 64'h0303030303030303,
               64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0};
      b_rd = '{64'h0, 64'h0, 64'h0101010101010101, 64'h0101010101010101,
               64'h0202020202020202, 64'h0303030303030303, 64'h0303030303030303,
               64'h0202020202020202};
      b_er = '{0, 0, 0, 0, 0, 0, 1, 0};

      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
         req_addr[d] = '0; req_wdata[d] = '0;
      end
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 64'h10;
      req_wdata[0] = 64'h1122334455667788;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, req_ready[0]}, 64'd1);
      chk("rst_stall", {63'd0, stall[0]}, 64'd0);
      chk("rst_valid", {63'd0, resp_valid[0]}, 64'd0);
      chk("rst_rdata", resp_rdata[0], 64'd0);
      chk("rst_err", {63'd0, resp_err[0]}, 64'd0);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      do_req(1'b1, 64'h10, 64'h1122334455667788, 64'h0, 1'b0);
      do_req(1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0);
      do_req(1'b1, 64'h08, 64'h0807060504030201, 64'h1122334455667788, 1'b0);
      do_req(1'b1, 64'h0C, 64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788, 1'b1);
      do_req(1'b0, 64'h08, 64'h0, 64'h0807060504030201, 1'b0);
      do_req(1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0);
      do_req(1'b0, 64'h0C, 64'h0, 64'h0, 1'b1);
      do_req(1'b1, 64'h48, 64'hA5A5, 64'h0, 1'b0);
      do_req(1'b0, 64'h08, 64'h0, 64'hA5A5, 1'b0);
      do_req(1'b1, 64'h20, 64'h5555AAAA00001234, 64'hA5A5, 1'b0);

      // Store aborted by a reset pulse in its WAIT cycle.
      req_valid[0] = 1'b1; req_write[0] = 1'b1;
      req_addr[0] = 64'h20; req_wdata[0] = 64'hDEAD;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("wait_stall", {63'd0, stall[0]}, 64'd1);
      rst_n[0] = 1'b0;
      #1;
      chk("midrst_ready", {63'd0, req_ready[0]}, 64'd1);
      chk("midrst_stall", {63'd0, stall[0]}, 64'd0);
      chk("midrst_valid", {63'd0, resp_valid[0]}, 64'd0);
      chk("midrst_rdata", resp_rdata[0], 64'd0);
      #1;
      rst_n[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      do_req(1'b0, 64'h20, 64'h0, 64'h5555AAAA00001234, 1'b0);

      // Back-to-back on instance 1; odd cycles carry junk that must be ignored.
      for (int i = 0; i < 16; i++) begin
         req_valid[1] = 1'b1;
         if (i % 2 == 0) begin
            req_write[1] = b_wr[i/2];
            req_addr[1]  = b_ad[i/2];
            req_wdata[1] = b_wd[i/2];
            q1.push_back('{b_er[i/2], b_rd[i/2]});
         end else begin
            req_write[1] = 1'b1;
            req_addr[1]  = 64'h00;
            req_wdata[1] = 64'hBADBADBADBADBAD0;
         end
         #1;
         chk("b2b_ready", {63'd0, req_ready[1]}, (i % 2 == 0) ? 64'd1 : 64'd0);
         chk("b2b_stall", {63'd0, stall[1]}, (i % 2 == 0) ? 64'd1 : 64'd0);
         chk("b2b_valid", {63'd0, resp_valid[1]}, (i % 2 == 0) ? 64'd0 : 64'd1);
         @(posedge clk); #1;
      end
      req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
